find_max_responder: RTL and testbench



---
 rtl/find_max_responder.sv | 96 +++++++++
 tb/tb_find_max_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/find_max_responder.sv
// find_max_responder: responder end of the find_max channel pair.
// Accepts COUNT words on the x stream, tracks their running maximum and
// returns it on the return stream, holding it until the initiator takes it.
// Optional build macro FIND_MAX_SIGNED_EN selects two's-complement signed
// comparison; without it the comparison is unsigned.
module find_max_responder #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned COUNT  = 8
) (
   input  logic              clk,
   input  logic              rst,
   output logic              x_in_busy,
   input  logic              x_in_vld,
   input  logic [DATA_W-1:0] x_in_data,
   input  logic              return_out_busy,
   output logic              return_out_vld,
   output logic [DATA_W-1:0] return_out_data
);

   localparam int unsigned CNT_W = $clog2(COUNT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

   typedef enum logic {
      ACCUM = 1'b0,
      SEND  = 1'b1
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] max_r;

   logic              x_acc_c;
   logic              x_gt_c;
   logic [DATA_W-1:0] next_max_c;

   // A word transfers when valid meets a not-busy responder in ACCUM.
   assign x_acc_c = x_in_vld & ~x_in_busy & (state == ACCUM);

   // Running-max candidate; ties keep the stored value.
   always_comb begin
      x_gt_c     = 1'b0;
      next_max_c = max_r;
`ifdef FIND_MAX_SIGNED_EN
      x_gt_c = $signed(x_in_data) > $signed(max_r);
`else
      x_gt_c = x_in_data > max_r;
`endif
      if (cnt == '0) begin
         next_max_c = x_in_data;
      end else if (x_gt_c) begin
         next_max_c = x_in_data;
      end
   end

   // Block FSM: accumulate COUNT words, then hold the result until taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ACCUM;
         cnt             <= '0;
         max_r           <= '0;
         x_in_busy       <= 1'b1;
         return_out_vld  <= 1'b0;
         return_out_data <= '0;
      end else begin
         case (state)
            ACCUM: begin
               x_in_busy      <= 1'b0;
               return_out_vld <= 1'b0;
               if (x_acc_c) begin
                  max_r <= next_max_c;
                  if (cnt == CNT_LAST) begin
                     state           <= SEND;
                     cnt             <= '0;
                     return_out_data <= next_max_c;
                     return_out_vld  <= 1'b1;
                     x_in_busy       <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            SEND: begin
               if (!return_out_busy) begin
                  state          <= ACCUM;
                  return_out_vld <= 1'b0;
                  x_in_busy      <= 1'b0;
               end
            end
            default: begin
               state <= ACCUM;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_find_max_responder.sv
// Bench for find_max_responder: a COUNT=8 and a COUNT=1 instance driven by
// directed steps, with expected block maxima queued as each block is driven.
module tb_find_max_responder;

   logic        clk;
   logic        rst;

   logic        x_busy8, x_vld8, ret_busy8, ret_vld8;
   logic [31:0] x_data8, ret_data8;
   logic        x_busy1, x_vld1, ret_busy1, ret_vld1;
   logic [31:0] x_data1, ret_data1;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] q8[$];
   logic [31:0] q1[$];
   logic [31:0] blk[8];

   find_max_responder #(.DATA_W(32), .COUNT(8)) u_dut8 (
      .clk             (clk),
      .rst             (rst),
      .x_in_busy       (x_busy8),
      .x_in_vld        (x_vld8),
      .x_in_data       (x_data8),
      .return_out_busy (ret_busy8),
      .return_out_vld  (ret_vld8),
      .return_out_data (ret_data8)
   );

   find_max_responder #(.DATA_W(32), .COUNT(1)) u_dut1 (
      .clk             (clk),
      .rst             (rst),
      .x_in_busy       (x_busy1),
      .x_in_vld        (x_vld1),
      .x_in_data       (x_data1),
      .return_out_busy (ret_busy1),
      .return_out_vld  (ret_vld1),
      .return_out_data (ret_data1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop if the directed sequence ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // Reference maximum, in the comparison domain of this build.
   function automatic logic [31:0] ref_max(input logic [31:0] b[8], input int n);
      logic [31:0] m;
      m = b[0];
      for (int i = 1; i < n; i++) begin
`ifdef FIND_MAX_SIGNED_EN
         if ($signed(b[i]) > $signed(m)) m = b[i];
`else
         if (b[i] > m) m = b[i];
`endif
      end
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the word transferred.
   task automatic send_x(input int which, input logic [31:0] d);
      int n;
      n = 0;
      if (which == 8) begin
         while (x_busy8 !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (n >= 20) chk("x_busy8_timeout", 32'(x_busy8), 32'd0);
         x_vld8  = 1'b1;
         x_data8 = d;
         @(negedge clk);
         x_vld8  = 1'b0;
      end else begin
         while (x_busy1 !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (n >= 20) chk("x_busy1_timeout", 32'(x_busy1), 32'd0);
         x_vld1  = 1'b1;
         x_data1 = d;
         @(negedge clk);
         x_vld1  = 1'b0;
      end
   endtask

   // Result must be visible in the cycle right after the last word.
   task automatic check_result(input int which, input string tag);
      logic [31:0] e;
      e = 32'hDEADBEEF;
      if (which == 8) begin
         if (q8.size() > 0) e = q8.pop_front();
         chk({tag, "_vld"},  32'(ret_vld8), 32'd1);
         chk({tag, "_data"}, ret_data8, e);
         chk({tag, "_busy"}, 32'(x_busy8), 32'd1);
      end else begin
         if (q1.size() > 0) e = q1.pop_front();
         chk({tag, "_vld"},  32'(ret_vld1), 32'd1);
         chk({tag, "_data"}, ret_data1, e);
         chk({tag, "_busy"}, 32'(x_busy1), 32'd1);
      end
   endtask

   initial begin
      rst       = 1'b1;
      x_vld8    = 1'b1;
      x_data8   = 32'h55;
      x_vld1    = 1'b1;
      x_data1   = 32'h66;
      ret_busy8 = 1'b0;
      ret_busy1 = 1'b0;

      // Reset held three cycles with valid asserted.
      repeat (3) begin
         @(negedge clk);
         chk("rst_busy8", 32'(x_busy8), 32'd1);
         chk("rst_vld8",  32'(ret_vld8), 32'd0);
         chk("rst_data8", ret_data8, 32'd0);
         chk("rst_busy1", 32'(x_busy1), 32'd1);
         chk("rst_vld1",  32'(ret_vld1), 32'd0);
      end
      rst    = 1'b0;
      x_vld8 = 1'b0;
      x_vld1 = 1'b0;
      @(negedge clk);
      chk("rel_busy8", 32'(x_busy8), 32'd0);
      chk("rel_busy1", 32'(x_busy1), 32'd0);

      // Basic block, back-to-back words.
      blk = '{32'd3, 32'd9, 32'd1, 32'd7, 32'd9, 32'd2, 32'd0, 32'd5};
      q8.push_back(ref_max(blk, 8));
      for (int i = 0; i < 8; i++) send_x(8, blk[i]);
      check_result(8, "basic");
      @(negedge clk);
      chk("basic_vld_drop",  32'(ret_vld8), 32'd0);
      chk("basic_busy_drop", 32'(x_busy8), 32'd0);

      // Back-pressured result; x valid offered during SEND must be ignored.
      ret_busy8 = 1'b1;
      q8.push_back(ref_max(blk, 8));
      for (int i = 0; i < 8; i++) send_x(8, blk[i]);
      check_result(8, "bp");
      x_vld8  = 1'b1;
      x_data8 = 32'h1000;
      repeat (10) begin
         @(negedge clk);
         chk("bp_hold_vld",  32'(ret_vld8), 32'd1);
         chk("bp_hold_data", ret_data8, 32'd9);
         chk("bp_hold_busy", 32'(x_busy8), 32'd1);
      end
      x_vld8    = 1'b0;
      ret_busy8 = 1'b0;
      @(negedge clk);
      chk("bp_vld_drop",  32'(ret_vld8), 32'd0);
      chk("bp_busy_drop", 32'(x_busy8), 32'd0);

      // Signedness: all-ones against small positives.
      blk = '{32'hFFFFFFFF, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
      q8.push_back(ref_max(blk, 8));
      for (int i = 0; i < 8; i++) send_x(8, blk[i]);
      check_result(8, "sign");
`ifdef FIND_MAX_SIGNED_EN
      chk("sign_value", ret_data8, 32'h00000001);
`else
      chk("sign_value", ret_data8, 32'hFFFFFFFF);
`endif

      // Gapped input: one idle cycle between words.
      @(negedge clk);
      blk = '{32'd10, 32'd200, 32'd30, 32'd40, 32'd250, 32'd60, 32'd70, 32'd80};
      q8.push_back(ref_max(blk, 8));
      for (int i = 0; i < 8; i++) begin
         send_x(8, blk[i]);
         if (i < 7) begin
            chk("gap_no_result", 32'(ret_vld8), 32'd0);
            @(negedge clk);
         end
      end
      check_result(8, "gap");

      // COUNT=1: every word is its own block.
      q1.push_back(32'h42);
      send_x(1, 32'h42);
      check_result(1, "c1a");
      q1.push_back(32'h7);
      send_x(1, 32'h7);
      check_result(1, "c1b");
      @(negedge clk);
      chk("c1_vld_drop", 32'(ret_vld1), 32'd0);

      // Reset mid-block discards the partial maximum.
      send_x(8, 32'd20);
      send_x(8, 32'd100);
      send_x(8, 32'd50);
      send_x(8, 32'd60);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", 32'(x_busy8), 32'd1);
      chk("mid_rst_vld",  32'(ret_vld8), 32'd0);
      rst = 1'b0;
      blk = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5};
      q8.push_back(ref_max(blk, 8));
      for (int i = 0; i < 8; i++) send_x(8, blk[i]);
      check_result(8, "post_rst");
      @(negedge clk);
      chk("post_rst_drop", 32'(ret_vld8), 32'd0);

      chk("q8_empty", 32'(q8.size()), 32'd0);
      chk("q1_empty", 32'(q1.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
